// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// stopwatch_pkg : shared state encoding, event indices and parameter defaults
// Rev 1.0 : initial release
// ============================================================================
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_OVF  = 2'd3
  } state_t;

  localparam int unsigned DEF_BASE_DIV  = 50000;
  localparam int unsigned DEF_MAX_COUNT = 9999;
  localparam int unsigned DEF_CW        = 15;

  // Bit positions of the conditioned button events
  localparam int unsigned EV_STOP = 0;
  localparam int unsigned EV_UP   = 1;
  localparam int unsigned EV_DOWN = 2;
  localparam int unsigned NUM_BTN = 3;

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// stopwatch_ctrl_if : buttons/switches in, count/tick/LEDs out
// Rev 1.0 : initial release
// ============================================================================
interface stopwatch_ctrl_if
  import stopwatch_pkg::*;
#(
  parameter int unsigned CW = DEF_CW
);

  logic          btn_stop;
  logic          btn_up;
  logic          btn_down;
  logic          choose_clock;
  logic [3:0]    frequency;
  logic [CW-1:0] count;
  logic          tick;
  logic          led_counting_up;
  logic          led_counting_down;
  logic          led_counting_overflow;

  modport master (
    output btn_stop, btn_up, btn_down, choose_clock, frequency,
    input  count, tick, led_counting_up, led_counting_down, led_counting_overflow
  );

  modport slave (
    input  btn_stop, btn_up, btn_down, choose_clock, frequency,
    output count, tick, led_counting_up, led_counting_down, led_counting_overflow
  );

endinterface
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// tick_prescaler : programmable period tick generator with restart
// Rev 1.0 : initial release
// ============================================================================
module tick_prescaler
  import stopwatch_pkg::*;
#(
  parameter int unsigned BASE_DIV = DEF_BASE_DIV
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       restart,
  input  wire logic       choose_clock,
  input  wire logic [3:0] frequency,
  output logic            tick
);

  localparam int unsigned PW = $clog2(BASE_DIV * 16) + 1;

  logic [PW-1:0] cnt;
  logic [PW-1:0] freq_p1;
  logic [PW-1:0] period;
  logic [PW-1:0] period_m1;
  logic [PW-1:0] next_cnt;

  always_comb begin
    freq_p1   = PW'(frequency) + PW'(1);
    period    = choose_clock ? freq_p1 : PW'(BASE_DIV) * freq_p1;
    period_m1 = period - PW'(1);
    next_cnt  = (restart || (cnt >= period_m1)) ? '0 : cnt + PW'(1);
  end

  // tick is registered so that it is high exactly while cnt sits at the
  // terminal value; the count therefore steps one full period after restart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= next_cnt;
      tick <= (next_cnt >= period_m1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// stopwatch_ctrl : button-driven up/down count FSM with tick scheduling
// Rev 1.0 : initial release
// ============================================================================
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned BASE_DIV  = DEF_BASE_DIV,
  parameter int unsigned MAX_COUNT = DEF_MAX_COUNT,
  parameter int unsigned CW        = DEF_CW
) (
  input wire logic        clk,
  input wire logic        reset,
  stopwatch_ctrl_if.slave bus
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] evt;
  logic               tick;
  logic               restart;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] count_q;
  logic [CW-1:0] next_count;
  logic          led_up;
  logic          led_down;
  logic          led_ovf;

  assign btn_raw[EV_STOP] = bus.btn_stop;
  assign btn_raw[EV_UP]   = bus.btn_up;
  assign btn_raw[EV_DOWN] = bus.btn_down;

  // Two-flop synchronizer, edge detector and a registered one-cycle event
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    logic sync1;
    logic sync2;
    logic sync3;
    logic event_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1   <= 1'b0;
        sync2   <= 1'b0;
        sync3   <= 1'b0;
        event_q <= 1'b0;
      end else begin
        sync1   <= btn_raw[i];
        sync2   <= sync1;
        sync3   <= sync2;
        event_q <= sync2 & ~sync3;
      end
    end

    assign evt[i] = event_q;
  end

  tick_prescaler #(
    .BASE_DIV (BASE_DIV)
  ) u_prescaler (
    .clk          (clk),
    .reset        (reset),
    .restart      (restart),
    .choose_clock (bus.choose_clock),
    .frequency    (bus.frequency),
    .tick         (tick)
  );

  always_comb begin
    next_state = state;
    next_count = count_q;
    restart    = 1'b0;
    if (evt[EV_STOP]) begin
      next_state = ST_IDLE;
    end else if (evt[EV_UP]) begin
      next_state = ST_UP;
      restart    = 1'b1;
    end else if (evt[EV_DOWN]) begin
      // Down from IDLE at zero is refused so the count can never underflow
      if ((state != ST_IDLE) || (count_q != '0)) begin
        next_state = ST_DOWN;
        restart    = 1'b1;
      end
    end else if (tick) begin
      case (state)
        ST_UP, ST_OVF: begin
          if (count_q >= MAX_C) begin
            next_count = '0;
            next_state = ST_OVF;
          end else begin
            next_count = count_q + ONE_C;
          end
        end
        ST_DOWN: begin
          if (count_q <= ONE_C) begin
            next_count = '0;
            next_state = ST_IDLE;
          end else begin
            next_count = count_q - ONE_C;
          end
        end
        default: begin
          next_count = count_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      count_q  <= '0;
      led_up   <= 1'b0;
      led_down <= 1'b0;
      led_ovf  <= 1'b0;
    end else begin
      state    <= next_state;
      count_q  <= next_count;
      led_up   <= (next_state == ST_UP) || (next_state == ST_OVF);
      led_down <= (next_state == ST_DOWN);
      led_ovf  <= (next_state == ST_OVF);
    end
  end

  assign bus.count                 = count_q;
  assign bus.tick                  = tick;
  assign bus.led_counting_up       = led_up;
  assign bus.led_counting_down     = led_down;
  assign bus.led_counting_overflow = led_ovf;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_stopwatch_ctrl : directed self-checking bench (BASE_DIV=4, MAX_COUNT=15)
// Rev 1.0 : initial release
// ============================================================================
module tb_stopwatch_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   passed;

  stopwatch_ctrl_if #(.CW(15)) bus ();

  stopwatch_ctrl #(
    .BASE_DIV  (4),
    .MAX_COUNT (15),
    .CW        (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic s, input logic u, input logic d);
    bus.btn_stop = s;
    bus.btn_up   = u;
    bus.btn_down = d;
    step(1);
    bus.btn_stop = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    checks           = 0;
    passed           = 0;
    reset            = 1'b1;
    bus.btn_stop     = 1'b0;
    bus.btn_up       = 1'b0;
    bus.btn_down     = 1'b0;
    bus.choose_clock = 1'b0;
    bus.frequency    = 4'd0;

    step(1);
    check("rst_count", bus.count, 0);
    check("rst_tick", bus.tick, 0);
    check("rst_leds", {bus.led_counting_up, bus.led_counting_down, bus.led_counting_overflow}, 0);
    step(2);
    reset = 1'b0;

    // Slow mode, period 4
    press(0, 1, 0);
    step(2);
    check("up_led_early", bus.led_counting_up, 0);
    step(1);
    check("up_led", bus.led_counting_up, 1);
    check("up_count0", bus.count, 0);
    check("up_tick_restart", bus.tick, 0);
    step(3);
    check("up_first_tick", bus.tick, 1);
    check("up_count_pre", bus.count, 0);
    step(1);
    check("up_tick_low", bus.tick, 0);
    check("up_count1", bus.count, 1);
    step(36);
    check("up_count10", bus.count, 10);

    step(20);
    check("ovf_count15", bus.count, 15);
    check("ovf_led_pre", bus.led_counting_overflow, 0);
    step(4);
    check("ovf_wrap", bus.count, 0);
    check("ovf_led", bus.led_counting_overflow, 1);
    check("ovf_up_led", bus.led_counting_up, 1);
    press(1, 0, 0);
    step(3);
    check("ovf_stop_leds", {bus.led_counting_up, bus.led_counting_down, bus.led_counting_overflow}, 0);
    check("ovf_stop_count", bus.count, 0);
    step(8);
    check("idle_hold0", bus.count, 0);

    // Count up to 3, then auto-stopping down count
    press(0, 1, 0);
    step(12);
    press(1, 0, 0);
    step(3);
    check("to3_count", bus.count, 3);
    check("to3_idle", bus.led_counting_up, 0);
    press(0, 0, 1);
    step(3);
    check("dn_led", bus.led_counting_down, 1);
    check("dn_count3", bus.count, 3);
    step(4);
    check("dn_count2", bus.count, 2);
    step(4);
    check("dn_count1", bus.count, 1);
    check("dn_led_still", bus.led_counting_down, 1);
    step(4);
    check("dn_count0", bus.count, 0);
    check("dn_autostop_led", bus.led_counting_down, 0);
    press(0, 0, 1);
    step(3);
    check("dn_at0_led", bus.led_counting_down, 0);
    check("dn_at0_count", bus.count, 0);
    step(5);
    check("dn_at0_hold", bus.count, 0);

    // Count up to 5, then simultaneous stop+up in IDLE
    press(0, 1, 0);
    step(20);
    press(1, 0, 0);
    step(3);
    check("to5_count", bus.count, 5);
    press(1, 1, 0);
    step(3);
    check("sim_led_up", bus.led_counting_up, 0);
    check("sim_count", bus.count, 5);
    step(4);
    check("sim_hold", bus.count, 5);

    // Up event coinciding with a tick while counting down
    press(0, 0, 1);
    step(7);
    check("dt_count4", bus.count, 4);
    check("dt_led_down", bus.led_counting_down, 1);
    press(0, 1, 0);
    step(2);
    check("dt_tick", bus.tick, 1);
    step(1);
    check("dt_led_up", bus.led_counting_up, 1);
    check("dt_led_down_off", bus.led_counting_down, 0);
    check("dt_count_kept", bus.count, 4);
    step(3);
    check("dt_count_pre", bus.count, 4);
    step(1);
    check("dt_count5", bus.count, 5);
    step(8);
    check("dt_count7", bus.count, 7);

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    check("arst_count", bus.count, 0);
    check("arst_leds", {bus.led_counting_up, bus.led_counting_down, bus.led_counting_overflow}, 0);
    check("arst_tick", bus.tick, 0);
    @(negedge clk);
    reset = 1'b0;
    step(1);
    check("arst_tick1", bus.tick, 0);
    step(1);
    check("arst_tick2", bus.tick, 0);
    step(1);
    check("arst_tick3", bus.tick, 1);
    check("arst_idle", bus.led_counting_up, 0);

    // Fast mode, period 3, then live change to period 1
    bus.choose_clock = 1'b1;
    bus.frequency    = 4'd2;
    press(0, 1, 0);
    step(3);
    check("fast_led", bus.led_counting_up, 1);
    check("fast_tick_s3", bus.tick, 0);
    step(1);
    check("fast_tick_s4", bus.tick, 0);
    step(1);
    check("fast_tick_s5", bus.tick, 1);
    step(1);
    check("fast_tick_s6", bus.tick, 0);
    check("fast_count1", bus.count, 1);
    step(2);
    check("fast_tick_s8", bus.tick, 1);
    step(1);
    check("fast_count2", bus.count, 2);
    step(1);
    bus.frequency = 4'd0;
    step(1);
    check("live_tick1", bus.tick, 1);
    check("live_count2", bus.count, 2);
    step(1);
    check("live_tick2", bus.tick, 1);
    check("live_count3", bus.count, 3);
    step(1);
    check("live_tick3", bus.tick, 1);
    check("live_count4", bus.count, 4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
